// File: rtl/sum_recover_pkg.sv
// Shared types and constants for the serial operand-recovery block.
package sum_recover_pkg;

  localparam int unsigned DefaultW = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Wide enough to count 0..W+1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/fsub_bit.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout is the borrow out.
module fsub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sum_operand_recover.sv
// Recovers A = Y - B bit-serially (LSB first) and flags results that do not fit in W bits.
module sum_operand_recover
  import sum_recover_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W:0]   Y,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] A_out,
  output logic         err
);

  localparam int unsigned CntW = cnt_width(W);

  state_e            state_q, state_d;
  logic [W:0]        ys_q, ys_d;
  logic [W:0]        bs_q, bs_d;
  logic [W:0]        diff_q, diff_d;
  logic              borrow_q, borrow_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [W-1:0]      a_q, a_d;
  logic              err_q, err_d;

  logic              d_bit;
  logic              bout;

  fsub_bit u_fsub_bit (
    .a    (ys_q[0]),
    .b    (bs_q[0]),
    .bin  (borrow_q),
    .d    (d_bit),
    .bout (bout)
  );

  always_comb begin
    state_d  = state_q;
    ys_d     = ys_q;
    bs_d     = bs_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    err_d    = err_q;
    done_d   = 1'b0;
    // busy and done are registered, so they trail the state by one edge.
    busy_d   = (state_q == StShift);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ys_d     = Y;
          bs_d     = {1'b0, B};
          diff_d   = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        // Difference bits enter at the MSB so the LSB lands at bit 0 after W+1 shifts.
        diff_d   = {d_bit, diff_q[W:1]};
        ys_d     = ys_q >> 1;
        bs_d     = bs_q >> 1;
        borrow_d = bout;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        a_d     = diff_q[W-1:0];
        err_d   = borrow_q | diff_q[W];
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ys_q     <= '0;
      bs_q     <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      a_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ys_q     <= ys_d;
      bs_q     <= bs_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      a_q      <= a_d;
      err_q    <= err_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign A_out = a_q;
  assign err   = err_q;

endmodule

// File: tb/tb_sum_operand_recover.sv
// Randomised and directed bench for sum_operand_recover against a cycle-timeline model.
module tb_sum_operand_recover;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W:0]   y = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] a_out;
  logic         err;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  sum_operand_recover #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .Y     (y),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .A_out (a_out),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Model: an accepted op at edge e is busy after edges e+1..e+W+1, reports after edge e+W+2,
  // and the block accepts again from edge e+W+3.
  int n = 0;
  int acc = -1;
  int pend_a = 0, pend_err = 0;
  int hold_a = 0, hold_err = 0;

  always @(posedge clk) begin
    int diff;
    n = n + 1;
    if (reset) begin
      acc = -1;
      hold_a = 0;
      hold_err = 0;
    end else begin
      if (acc >= 0 && n == acc + W + 2) begin
        hold_a = pend_a;
        hold_err = pend_err;
      end
      if ((acc < 0 || n > acc + W + 2) && start) begin
        acc = n;
        diff = int'(y) - int'(b);
        pend_a = (diff + 2 * (2 ** W)) % (2 ** W);
        pend_err = (diff < 0 || diff > (2 ** W) - 1) ? 1 : 0;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (n >= 1) begin
      chk("busy", int'(busy), (acc >= 0 && n >= acc + 1 && n <= acc + W + 1) ? 1 : 0);
      chk("done", int'(done), (acc >= 0 && n == acc + W + 2) ? 1 : 0);
      chk("A_out", int'(a_out), hold_a);
      chk("err", int'(err), hold_err);
      if (done) done_cnt++;
    end
  end

  // Starts one operation from idle; inputs are scrambled after the accepting edge.
  task automatic run_op(input int yv, input int bv, input int exp_a, input int exp_err);
    int lat;
    @(negedge clk);
    y = 4'(yv);
    b = 3'(bv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    y = 4'($urandom_range(0, 15));
    b = 3'($urandom_range(0, 7));
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, W + 2);
    chk("op_A", int'(a_out), exp_a);
    chk("op_err", int'(err), exp_err);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  initial begin
    int dc0;
    #12;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_A", int'(a_out), 0);
    chk("rst_err", int'(err), 0);

    run_op(3, 1, 2, 0);
    idle_cycles(1);
    run_op(8, 3, 5, 0);
    idle_cycles(1);
    run_op(9, 2, 7, 0);
    idle_cycles(1);
    run_op(9, 6, 3, 0);
    idle_cycles(1);
    run_op(0, 0, 0, 0);
    idle_cycles(1);
    run_op(2, 5, 5, 1);
    idle_cycles(1);
    run_op(15, 0, 7, 1);
    idle_cycles(2);

    // Second start during SHIFT must be ignored.
    dc0 = done_cnt;
    @(negedge clk);
    y = 4'd3; b = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    y = 4'd15; b = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle_cycles(8);
    chk("ign_done_count", done_cnt - dc0, 1);
    chk("ign_A", int'(a_out), 2);
    chk("ign_err", int'(err), 0);

    // Reset on the second SHIFT edge aborts without a done pulse.
    dc0 = done_cnt;
    @(negedge clk);
    y = 4'd15; b = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_A", int'(a_out), 0);
    idle_cycles(8);
    chk("abort_no_done", done_cnt - dc0, 0);
    run_op(3, 1, 2, 0);
    idle_cycles(2);

    // Random traffic, including starts while busy and occasional resets.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      y = 4'($urandom_range(0, 15));
      b = 3'($urandom_range(0, 7));
      start = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 59) == 0);
    end
    start = 1'b0;
    reset = 1'b0;
    idle_cycles(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_operand_recover.md
Name: sum_operand_recover

Overview:
Inverse end of the registered 3-bit operand adder. It receives a (W+1)-bit sum Y and one W-bit operand B, then recovers the other operand A = Y - B. It uses a bit-serial subtractor, LSB first, under a start/done handshake. It flags results that do not fit in W unsigned bits, so a bench or checker can close the loop on the adder's output.

Parameters:
W, 3, operand width; sum input is W+1 bits, recovered operand is W bits.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; clears all state on the next rising edge of clk
start  input  1  request; sampled only in IDLE
Y  input  W+1  sum to decompose; captured at the accepting edge
B  input  W  known operand; captured at the accepting edge
busy  output  1  high while bits are being processed (state SHIFT)
done  output  1  one-cycle pulse; A_out and err are valid in this cycle
A_out  output  W  recovered operand, low W bits of Y - B
err  output  1  result not representable: Y < B, or Y - B > 2^W - 1

Behaviour:
- Reset, synchronous: state=IDLE, busy=0, done=0, A_out=0, err=0, shift registers=0, borrow=0, bit counter=0.
- States are IDLE, SHIFT and DONE.
- IDLE: if start=1 at an edge:
  - load ys<=Y and bs<={1'b0,B} (zero-extended to W+1);
  - borrow<=0, cnt<=0, clear result register;
  - next state SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, per edge:
  - d = ys[0] ^ bs[0] ^ borrow;
  - borrow <= (~ys[0] & bs[0]) | (~(ys[0] ^ bs[0]) & borrow);
  - shift d into the result register MSB-first-fill, and shift ys and bs right by one;
  - cnt<=cnt+1.
  - After W+1 edges (cnt==W), next state is DONE.
- DONE:
  - done=1 for exactly one cycle.
  - A_out<=D[W-1:0], where D is the (W+1)-bit difference.
  - err<=final borrow | D[W].
  - Next edge returns to IDLE.
- Latency: with start accepted at edge 0, SHIFT occupies edges 1..W+1.
  - done is high in the cycle after edge W+2, i.e. edge W+2 registers the outputs.
  - For W=3, done is seen after edge 5.
  - busy is high after edges 1..W+1.
- A_out and err hold their value after done until the next DONE or reset.
- start is ignored while in SHIFT or DONE. No queuing: a start held high continuously re-triggers in IDLE.
- Y and B may change freely after the accepting edge without affecting the result in flight.
- Reset asserted mid-operation aborts the operation. The next cycle is IDLE with all outputs 0, and no done pulse is produced.
- Wrap rule: A_out is always (Y - B) mod 2^W, even when err=1.

Decomposition:
- Shared package (sum_recover_pkg):
  - default W=3;
  - state encoding IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - counter width $clog2(W+2).
- One natural sub-module: fsub_bit, a combinational 1-bit full subtractor with inputs a, b, bin and outputs d, bout. It is instantiated once inside the serial datapath; the borrow flop lives in the parent.

Test Plan:
- Reset held 12 ns, Y=0, B=0 -> busy=0, done=0, A_out=0, err=0 throughout reset and after.
- start with Y=4'd3, B=3'd1 -> done pulse after 5 edges, A_out=3'd2, err=0. Repeat with Y=8, B=3 -> A_out=5, err=0.
- Boundary cases:
  - Y=4'd9, B=3'd2 -> A_out=7, err=0;
  - Y=4'd9, B=3'd6 -> A_out=3, err=0;
  - Y=4'd0, B=3'd0 -> A_out=0, err=0.
- Error cases:
  - Y=4'd2, B=3'd5 (underflow) -> A_out=3'd5 (13 mod 8), err=1;
  - Y=4'd15, B=3'd0 (overflow) -> A_out=3'd7, err=1.
- Second start pulsed during SHIFT with different Y/B -> ignored. First result completes unchanged, and exactly one done pulse occurs.
- reset asserted on the 2nd SHIFT edge -> next cycle IDLE, busy=0, no done. A fresh start with Y=3, B=1 then yields A_out=2 normally.
